// File: rtl/ci_issue_if.sv
// Bundles the request, response and custom-instruction slave signals of ci_issue_master.
// The master modport is the issuing block; the slave modport is the host/FP-unit side.
interface ci_issue_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_dataa;
  logic [DATA_W-1:0] req_datab;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_timeout;

  logic              ci_clk_en;
  logic              ci_reset;
  logic              ci_start;
  logic [DATA_W-1:0] ci_dataa;
  logic [DATA_W-1:0] ci_datab;
  logic [DATA_W-1:0] ci_result;
  logic              ci_done;

  logic              spurious;

  modport master (
    input  req_valid, req_dataa, req_datab, rsp_ready, ci_result, ci_done,
    output req_ready, rsp_valid, rsp_result, rsp_timeout,
           ci_clk_en, ci_reset, ci_start, ci_dataa, ci_datab, spurious
  );

  modport slave (
    output req_valid, req_dataa, req_datab, rsp_ready, ci_result, ci_done,
    input  req_ready, rsp_valid, rsp_result, rsp_timeout,
           ci_clk_en, ci_reset, ci_start, ci_dataa, ci_datab, spurious
  );
endinterface

// File: rtl/ci_issue_master.sv
// Issues one operand pair at a time as a multi-cycle custom instruction and returns the result,
// with a watchdog that aborts and resets a slave that never signals done.
//
// state | meaning
// IDLE  | ready for operands, slave clock frozen
// ISSUE | single-cycle start strobe to the slave, watchdog loaded
// WAIT  | slave running, watchdog counting down to abort
// HOLD  | response presented until consumer accepts it
module ci_issue_master #(
  parameter int DATA_W  = 32,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic         clk,
  input  logic         aclr_n,
  ci_issue_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // Down-counter reaching zero on the TIMEOUT-th WAIT cycle without done.
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT - 1);

  state_t            r_state;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_result;
  logic              r_rsp_timeout;
  logic              r_ci_clk_en;
  logic              r_ci_reset;
  logic              r_ci_start;
  logic [DATA_W-1:0] r_ci_dataa;
  logic [DATA_W-1:0] r_ci_datab;
  logic              r_spurious;
  logic [TO_W-1:0]   r_timer;

  logic              w_req_ready;
  logic              w_done_idle;

  assign w_req_ready = aclr_n && (r_state == S_IDLE);
  assign w_done_idle = bus.ci_done && ((r_state == S_IDLE) || (r_state == S_HOLD));

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_state       <= S_IDLE;
      r_rsp_valid   <= 1'b0;
      r_rsp_result  <= '0;
      r_rsp_timeout <= 1'b0;
      r_ci_clk_en   <= 1'b0;
      r_ci_reset    <= 1'b0;
      r_ci_start    <= 1'b0;
      r_ci_dataa    <= '0;
      r_ci_datab    <= '0;
      r_spurious    <= 1'b0;
      r_timer       <= '0;
    end else begin
      r_ci_start <= 1'b0;
      r_ci_reset <= 1'b0;
      if (w_done_idle) begin
        r_spurious <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_ci_dataa  <= bus.req_dataa;
            r_ci_datab  <= bus.req_datab;
            r_ci_start  <= 1'b1;
            r_ci_clk_en <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          r_timer <= TO_LOAD;
          if (bus.ci_done) begin
            r_rsp_result  <= bus.ci_result;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_ci_clk_en   <= 1'b0;
            r_state       <= S_HOLD;
          end else begin
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          // A done arriving on the terminal cycle still counts as success.
          if (bus.ci_done) begin
            r_rsp_result  <= bus.ci_result;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_ci_clk_en   <= 1'b0;
            r_state       <= S_HOLD;
          end else if (r_timer == '0) begin
            r_ci_reset    <= 1'b1;
            r_rsp_result  <= '0;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_ci_clk_en   <= 1'b0;
            r_state       <= S_HOLD;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end

        S_HOLD: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready   = w_req_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_result  = r_rsp_result;
  assign bus.rsp_timeout = r_rsp_timeout;
  assign bus.ci_clk_en   = r_ci_clk_en;
  assign bus.ci_reset    = r_ci_reset;
  assign bus.ci_start    = r_ci_start;
  assign bus.ci_dataa    = r_ci_dataa;
  assign bus.ci_datab    = r_ci_datab;
  assign bus.spurious    = r_spurious;

endmodule

// File: tb/tb_ci_issue_master.sv
// Directed bench for ci_issue_master: a stub slave driven by hand (or zero-latency adder mode)
// with hand-computed expectations checked by immediate assertions.
`timescale 1ns/1ps

module tb_ci_issue_master;

  logic clk;
  logic aclr_n;
  int   checks;
  int   failures;
  int   start_cnt;
  int   reset_cnt;
  int   s0;
  int   r0;

  logic        zl_mode;
  logic        man_done;
  logic [31:0] man_result;

  logic [31:0] va [3];
  logic [31:0] vb [3];
  logic [31:0] ve [3];

  ci_issue_if #(.DATA_W(32)) bus ();

  ci_issue_master #(
    .DATA_W (32),
    .TO_W   (8),
    .TIMEOUT(8)
  ) dut (
    .clk   (clk),
    .aclr_n(aclr_n),
    .bus   (bus)
  );

  // Zero-latency mode: slave answers a+b in the same cycle as start.
  assign bus.ci_done   = zl_mode ? bus.ci_start : man_done;
  assign bus.ci_result = zl_mode ? (bus.ci_dataa + bus.ci_datab) : man_result;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ci_start === 1'b1) start_cnt++;
    if (bus.ci_reset === 1'b1) reset_cnt++;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  initial begin
    clk        = 1'b0;
    checks     = 0;
    failures   = 0;
    start_cnt  = 0;
    reset_cnt  = 0;
    zl_mode    = 1'b0;
    man_done   = 1'b0;
    man_result = 32'h0;
    va[0] = 32'h0000_0001; vb[0] = 32'h0000_0002; ve[0] = 32'h0000_0003;
    va[1] = 32'hFFFF_0000; vb[1] = 32'h0000_FFFF; ve[1] = 32'hFFFF_FFFF;
    va[2] = 32'h1234_5678; vb[2] = 32'h1111_1111; ve[2] = 32'h2345_6789;

    // Reset held with a pending request
    aclr_n        = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_dataa = 32'hDEAD_BEEF;
    bus.req_datab = 32'hCAFE_BABE;
    bus.rsp_ready = 1'b0;
    tick(3);
    chk("rst_req_ready", bus.req_ready, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_result", bus.rsp_result, 32'h0);
    chk("rst_rsp_timeout", bus.rsp_timeout, 1'b0);
    chk("rst_ci_clk_en", bus.ci_clk_en, 1'b0);
    chk("rst_ci_reset", bus.ci_reset, 1'b0);
    chk("rst_ci_start", bus.ci_start, 1'b0);
    chk("rst_ci_dataa", bus.ci_dataa, 32'h0);
    chk("rst_ci_datab", bus.ci_datab, 32'h0);
    chk("rst_spurious", bus.spurious, 1'b0);
    bus.req_valid = 1'b0;
    aclr_n        = 1'b1;
    #1;
    chk("post_rst_req_ready", bus.req_ready, 1'b1);
    tick();
    chk("idle_no_start", bus.ci_start, 1'b0);

    // Slave with 3 busy cycles between start and done
    bus.req_valid = 1'b1;
    bus.req_dataa = 32'h3F0B_851F;
    bus.req_datab = 32'h40AA_60FE;
    tick();
    s0 = start_cnt;
    chk("issue_start", bus.ci_start, 1'b1);
    chk("issue_clk_en", bus.ci_clk_en, 1'b1);
    chk("issue_dataa", bus.ci_dataa, 32'h3F0B_851F);
    chk("issue_datab", bus.ci_datab, 32'h40AA_60FE);
    chk("issue_req_ready", bus.req_ready, 1'b0);
    bus.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wait_start_low", bus.ci_start, 1'b0);
      chk("wait_clk_en", bus.ci_clk_en, 1'b1);
      chk("wait_no_rsp", bus.rsp_valid, 1'b0);
    end
    man_done   = 1'b1;
    man_result = 32'h1234_5678;
    tick();
    man_done = 1'b0;
    chk("lat3_rsp_valid", bus.rsp_valid, 1'b1);
    chk("lat3_rsp_result", bus.rsp_result, 32'h1234_5678);
    chk("lat3_rsp_timeout", bus.rsp_timeout, 1'b0);
    chk("lat3_clk_en_off", bus.ci_clk_en, 1'b0);
    chk("lat3_one_start", start_cnt - s0, 1);

    // Stall in HOLD with a new request waiting
    bus.req_valid = 1'b1;
    bus.req_dataa = 32'h1111_1111;
    bus.req_datab = 32'h2222_2222;
    man_result    = 32'h0BAD_0BAD;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_rsp_valid", bus.rsp_valid, 1'b1);
      chk("hold_rsp_result", bus.rsp_result, 32'h1234_5678);
      chk("hold_req_ready", bus.req_ready, 1'b0);
      chk("hold_clk_en", bus.ci_clk_en, 1'b0);
      chk("hold_dataa_kept", bus.ci_dataa, 32'h3F0B_851F);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("hold_accept_valid", bus.rsp_valid, 1'b0);
    chk("hold_accept_idle", bus.req_ready, 1'b1);
    chk("no_spurious_yet", bus.spurious, 1'b0);

    // Zero-latency slave, three back-to-back requests
    zl_mode       = 1'b1;
    s0            = start_cnt;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.req_dataa = va[i];
      bus.req_datab = vb[i];
      tick();
      chk("zl_start", bus.ci_start, 1'b1);
      chk("zl_dataa", bus.ci_dataa, va[i]);
      tick();
      chk("zl_rsp_valid", bus.rsp_valid, 1'b1);
      chk("zl_rsp_result", bus.rsp_result, ve[i]);
      chk("zl_rsp_timeout", bus.rsp_timeout, 1'b0);
      tick();
      chk("zl_back_idle", bus.req_ready, 1'b1);
      chk("zl_rsp_dropped", bus.rsp_valid, 1'b0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    zl_mode       = 1'b0;
    tick();
    chk("zl_three_starts", start_cnt - s0, 3);
    chk("zl_no_spurious", bus.spurious, 1'b0);

    // Watchdog: slave never answers, TIMEOUT=8
    bus.req_valid = 1'b1;
    bus.req_dataa = 32'hAAAA_5555;
    bus.req_datab = 32'h5555_AAAA;
    tick();
    chk("to_issue", bus.ci_start, 1'b1);
    bus.req_valid = 1'b0;
    r0 = reset_cnt;
    tick();
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("to_wait_no_reset", bus.ci_reset, 1'b0);
      chk("to_wait_no_rsp", bus.rsp_valid, 1'b0);
      chk("to_wait_clk_en", bus.ci_clk_en, 1'b1);
    end
    tick();
    chk("to_ci_reset", bus.ci_reset, 1'b1);
    chk("to_rsp_valid", bus.rsp_valid, 1'b1);
    chk("to_rsp_timeout", bus.rsp_timeout, 1'b1);
    chk("to_rsp_result", bus.rsp_result, 32'h0);
    chk("to_clk_en_off", bus.ci_clk_en, 1'b0);
    tick();
    chk("to_reset_pulse_end", bus.ci_reset, 1'b0);
    chk("to_hold_valid", bus.rsp_valid, 1'b1);
    chk("to_one_reset", reset_cnt - r0, 1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("to_accept", bus.rsp_valid, 1'b0);

    // Done on the terminal watchdog cycle wins over the timeout
    bus.req_valid = 1'b1;
    bus.req_dataa = 32'h0000_0010;
    bus.req_datab = 32'h0000_0020;
    tick();
    bus.req_valid = 1'b0;
    r0 = reset_cnt;
    tick(8);
    chk("edge_still_wait", bus.rsp_valid, 1'b0);
    man_done   = 1'b1;
    man_result = 32'hCAFE_F00D;
    tick();
    man_done = 1'b0;
    chk("edge_rsp_valid", bus.rsp_valid, 1'b1);
    chk("edge_rsp_timeout", bus.rsp_timeout, 1'b0);
    chk("edge_rsp_result", bus.rsp_result, 32'hCAFE_F00D);
    chk("edge_no_ci_reset", bus.ci_reset, 1'b0);
    tick();
    chk("edge_no_reset_pulse", reset_cnt - r0, 0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("edge_accept", bus.req_ready, 1'b1);

    // Spurious done in IDLE
    man_done   = 1'b1;
    man_result = 32'h7777_7777;
    tick();
    man_done = 1'b0;
    chk("spur_set", bus.spurious, 1'b1);
    chk("spur_no_rsp", bus.rsp_valid, 1'b0);
    chk("spur_idle", bus.req_ready, 1'b1);
    tick();
    chk("spur_sticky", bus.spurious, 1'b1);

    // Reset in the middle of WAIT abandons the operation
    bus.req_valid = 1'b1;
    bus.req_dataa = 32'h0101_0101;
    bus.req_datab = 32'h0202_0202;
    tick();
    bus.req_valid = 1'b0;
    tick(2);
    chk("mid_wait_clk_en", bus.ci_clk_en, 1'b1);
    aclr_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", bus.req_ready, 1'b0);
    chk("mid_rst_clk_en", bus.ci_clk_en, 1'b0);
    chk("mid_rst_spurious", bus.spurious, 1'b0);
    chk("mid_rst_dataa", bus.ci_dataa, 32'h0);
    tick();
    aclr_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("mid_rst_no_rsp", bus.rsp_valid, 1'b0);
      chk("mid_rst_idle", bus.req_ready, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
